// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-network readout stage.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NEURONS_OUT      = 8;
  localparam int SPIKE_COUNT_BITS = 8;
  localparam int WINDOW_BITS      = 8;

  // All-ones value of a counter of the given width.
  function automatic int sat_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating spike counter with synchronous clear; clear wins over enable.
// Single-cycle update, holds at all-ones instead of wrapping.
module snn_sat_counter
  import snn_pkg::*;
#(
  parameter int COUNT_BITS = SPIKE_COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [COUNT_BITS-1:0] o_count
);

  localparam logic [COUNT_BITS-1:0] MAX_CNT = COUNT_BITS'(sat_max(COUNT_BITS));

  logic [COUNT_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/snn_spike_readout.sv
// Rate-coded class readout: counts spikes per neuron over a window, then scans for the argmax.
// Result valid NEURONS cycles after the last step; no backpressure, steps outside ACCUM are dropped.
module snn_spike_readout
  import snn_pkg::*;
#(
  parameter int  NEURONS     = NEURONS_OUT,
  parameter int  COUNT_BITS  = SPIKE_COUNT_BITS,
  parameter int  WINDOW_BITS = snn_pkg::WINDOW_BITS,
  localparam int IDX_BITS    = $clog2(NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic                   spikes_valid,
  input  logic [NEURONS-1:0]     spikes,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_BITS-1:0]    winner,
  output logic [COUNT_BITS-1:0]  winner_count,
  output logic                   tie,
  input  logic [IDX_BITS-1:0]    read_sel,
  output logic [COUNT_BITS-1:0]  read_data
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WINDOW_BITS-1:0] r_win;
  logic [WINDOW_BITS-1:0] r_step;
  logic [IDX_BITS-1:0]    r_scan;
  logic [IDX_BITS-1:0]    r_winner;
  logic [COUNT_BITS-1:0]  r_best;
  logic                   r_tie;

  logic                   w_cnt_clr;
  logic                   w_step_acc;
  logic [WINDOW_BITS:0]   w_step_inc;
  logic                   w_last_step;
  logic                   w_scan_last;
  logic [COUNT_BITS-1:0]  w_scan_val;
  logic [COUNT_BITS-1:0]  w_count  [NEURONS];
  logic [COUNT_BITS-1:0]  w_rd_tbl [2**IDX_BITS];

  assign w_cnt_clr   = clear | start;
  assign w_step_acc  = (r_state == ACCUM) & spikes_valid & ~w_cnt_clr;
  assign w_step_inc  = {1'b0, r_step} + 1'b1;
  assign w_last_step = (w_step_inc == {1'b0, r_win});
  assign w_scan_last = (r_scan == IDX_BITS'(NEURONS - 1));

  genvar gi;
  for (gi = 0; gi < NEURONS; gi++) begin : g_cnt
    snn_sat_counter #(
      .COUNT_BITS(COUNT_BITS)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_cnt_clr),
      .i_en   (w_step_acc & spikes[gi]),
      .o_count(w_count[gi])
    );
  end

  // Padded to a power of two so out-of-range selects read back as zero.
  for (gi = 0; gi < 2**IDX_BITS; gi++) begin : g_rd
    if (gi < NEURONS) begin : g_live
      assign w_rd_tbl[gi] = w_count[gi];
    end else begin : g_pad
      assign w_rd_tbl[gi] = '0;
    end
  end

  assign read_data  = w_rd_tbl[read_sel];
  assign w_scan_val = w_rd_tbl[r_scan];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      w_state_nxt = (window_len == '0) ? ARGMAX : ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (spikes_valid && w_last_step) w_state_nxt = ARGMAX;
        ARGMAX:  if (w_scan_last) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win    <= '0;
      r_step   <= '0;
      r_scan   <= '0;
      r_winner <= '0;
      r_best   <= '0;
      r_tie    <= 1'b0;
    end else if (w_cnt_clr) begin
      if (start && !clear) begin
        r_win <= window_len;
      end
      r_step   <= '0;
      r_scan   <= '0;
      r_winner <= '0;
      r_best   <= '0;
      r_tie    <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (spikes_valid) begin
            r_step <= w_step_inc[WINDOW_BITS-1:0];
          end
        end
        ARGMAX: begin
          r_scan <= r_scan + 1'b1;
          // Strict compare keeps the lowest index on equal counts.
          if (r_scan == '0) begin
            r_best   <= w_scan_val;
            r_winner <= '0;
            r_tie    <= 1'b0;
          end else if (w_scan_val > r_best) begin
            r_best   <= w_scan_val;
            r_winner <= r_scan;
            r_tie    <= 1'b0;
          end else if (w_scan_val == r_best) begin
            r_tie <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state == ACCUM) || (r_state == ARGMAX);
  assign result_valid = (r_state == DONE);
  assign winner       = r_winner;
  assign winner_count = r_best;
  assign tie          = r_tie;

endmodule

// File: tb/tb_snn_spike_readout.sv
// Scoreboard bench: reference model of spike windows feeds expectations, a monitor checks each result.
module tb_snn_spike_readout;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic [7:0] window_len;
  logic       spikes_valid;
  logic [7:0] spikes;
  logic [2:0] read_sel;

  logic       busy8, rv8, tie8;
  logic [2:0] win8;
  logic [7:0] wc8, rd8;
  logic       busy4, rv4, tie4;
  logic [2:0] win4;
  logic [3:0] wc4, rd4;

  snn_spike_readout u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .window_len(window_len),
    .spikes_valid(spikes_valid), .spikes(spikes), .busy(busy8), .result_valid(rv8),
    .winner(win8), .winner_count(wc8), .tie(tie8), .read_sel(read_sel), .read_data(rd8)
  );

  snn_spike_readout #(.COUNT_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .window_len(window_len),
    .spikes_valid(spikes_valid), .spikes(spikes), .busy(busy4), .result_valid(rv4),
    .winner(win4), .winner_count(wc4), .tie(tie4), .read_sel(read_sel), .read_data(rd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int e_end;
    int w8; int c8; bit t8;
    int w4; int c4; bit t4;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   checks = 0;
  int   fails  = 0;

  int   m8[8];
  int   m4[8];
  bit   m_acc = 0;
  int   m_step = 0;
  int   m_win = 0;
  bit   m_pend = 0;
  int   m_pend_end = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Winner is the lowest index holding the maximum; tie when the maximum occurs more than once.
  function automatic void ref_argmax(input int c[8], output int w, output int mxv, output bit t);
    int n;
    mxv = -1; w = 0; n = 0;
    for (int i = 0; i < 8; i++) if (c[i] > mxv) begin mxv = c[i]; w = i; end
    for (int i = 0; i < 8; i++) if (c[i] == mxv) n++;
    t = (n > 1);
  endfunction

  task automatic push_exp(input int e);
    exp_t x;
    x.e_end = e;
    ref_argmax(m8, x.w8, x.c8, x.t8);
    ref_argmax(m4, x.w4, x.c4, x.t4);
    q.push_back(x);
    m_pend = 1;
    m_pend_end = e;
  endtask

  task automatic drop_pending(input int e);
    if (m_pend && (e <= m_pend_end + N) && (q.size() > 0)) void'(q.pop_back());
    m_pend = 0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 8; i++) begin m8[i] = 0; m4[i] = 0; end
  endtask

  task automatic step(input bit v, input logic [7:0] sp, input bit st, input bit cl, input logic [7:0] wl);
    int e;
    spikes_valid = v; spikes = sp; start = st; clear = cl; window_len = wl;
    e = cyc + 1;
    if (cl || st) begin
      drop_pending(e);
      zero_model();
      m_acc = 0;
      if (!cl) begin
        m_win = int'(wl);
        m_step = 0;
        if (wl == 8'd0) push_exp(e);
        else m_acc = 1;
      end
    end else if (m_acc && v) begin
      for (int i = 0; i < 8; i++) if (sp[i]) begin
        if (m8[i] < 255) m8[i]++;
        if (m4[i] < 15) m4[i]++;
      end
      m_step++;
      if (m_step == m_win) begin
        m_acc = 0;
        push_exp(e);
      end
    end
    @(posedge clk);
    #1;
    spikes_valid = 1'b0; start = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!rv8 && n < 30) begin
      idle(1);
      n++;
    end
    chk({nm, "_done_seen"}, int'(rv8), 1);
  endtask

  task automatic readout(input string nm);
    for (int s = 0; s < 8; s++) begin
      read_sel = 3'(s);
      #1;
      chk($sformatf("%s_rd8[%0d]", nm, s), int'(rd8), m8[s]);
      chk($sformatf("%s_rd4[%0d]", nm, s), int'(rd4), m4[s]);
    end
  endtask

  bit prev_rv = 0;
  always @(negedge clk) begin
    if (rst_n && rv8 && !prev_rv) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mx = q.pop_front();
        m_pend = (q.size() > 0) ? m_pend : 1'b0;
        chk("latency", cyc, mx.e_end + N);
        chk("winner8", int'(win8), mx.w8);
        chk("count8", int'(wc8), mx.c8);
        chk("tie8", int'(tie8), int'(mx.t8));
        chk("valid4", int'(rv4), 1);
        chk("winner4", int'(win4), mx.w4);
        chk("count4", int'(wc4), mx.c4);
        chk("tie4", int'(tie4), int'(mx.t4));
        chk("busy_in_done", int'(busy8), 0);
      end
    end
    prev_rv <= rst_n ? rv8 : 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl, k, newwl, n;
    bit ab;
    logic [7:0] sp;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; window_len = 8'd0;
    spikes_valid = 1'b0; spikes = 8'd0; read_sel = 3'd0;
    zero_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_valid", int'(rv8), 0);
    chk("rst_winner", int'(win8), 0);
    chk("rst_count", int'(wc8), 0);
    chk("rst_tie", int'(tie8), 0);
    readout("rst");
    rst_n = 1'b1;
    idle(2);

    // Single active neuron.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd4);
    repeat (4) step(1'b1, 8'h04, 1'b0, 1'b0, 8'd0);
    wait_done("basic");
    chk("basic_winner", int'(win8), 2);
    chk("basic_count", int'(wc8), 4);
    readout("basic");

    // Equal counts on neurons 1 and 7.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd3);
    repeat (3) step(1'b1, 8'h82, 1'b0, 1'b0, 8'd0);
    wait_done("tie");
    chk("tie_flag", int'(tie8), 1);
    readout("tie");

    // Empty window goes straight to the scan.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
    wait_done("zero");
    chk("zero_tie", int'(tie8), 1);

    // Restart mid-window, the restarting cycle's step is discarded.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd5);
    repeat (3) step(1'b1, 8'h08, 1'b0, 1'b0, 8'd0);
    step(1'b1, 8'h08, 1'b1, 1'b0, 8'd2);
    repeat (2) step(1'b1, 8'h40, 1'b0, 1'b0, 8'd0);
    wait_done("abort");
    readout("abort");

    // Clear beats start.
    step(1'b1, 8'h01, 1'b1, 1'b1, 8'd3);
    chk("prio_busy", int'(busy8), 0);
    chk("prio_valid", int'(rv8), 0);
    chk("prio_count", int'(wc8), 0);
    idle(12);
    step(1'b1, 8'h01, 1'b1, 1'b0, 8'd2);
    repeat (2) step(1'b1, 8'h10, 1'b0, 1'b0, 8'd0);
    wait_done("coinc");
    readout("coinc");

    // Long window: 4-bit build saturates, 8-bit build reaches its maximum exactly.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd255);
    repeat (255) step(1'b1, 8'h01, 1'b0, 1'b0, 8'd0);
    wait_done("sat");
    chk("sat_count4", int'(wc4), 15);
    readout("sat");

    // Asynchronous reset in the middle of a window.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd10);
    repeat (3) step(1'b1, 8'hFF, 1'b0, 1'b0, 8'd0);
    #2;
    rst_n = 1'b0;
    drop_pending(cyc + 1);
    zero_model();
    m_acc = 0;
    #1;
    chk("arst_busy", int'(busy8), 0);
    chk("arst_valid", int'(rv8), 0);
    chk("arst_count", int'(wc8), 0);
    chk("arst_tie", int'(tie8), 0);
    readout("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12);

    for (int w = 0; w < 16; w++) begin
      wl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      ab = ($urandom_range(0, 3) == 0);
      k  = (wl > 0) ? int'($urandom_range(0, wl - 1)) : 0;
      newwl = int'($urandom_range(1, 10));
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'(wl));
      n = 0;
      while (m_acc && n < 100) begin
        sp = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        if (ab && n == k) begin
          step(1'($urandom_range(0, 1)), sp, 1'b1, 1'b0, 8'(newwl));
          ab = 0;
        end else begin
          step(1'($urandom_range(0, 3) != 0), sp, 1'b0, 1'b0, 8'd0);
        end
        n++;
      end
      wait_done("rand");
      readout("rand");
    end

    idle(2);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/snn_spike_readout.md
Name: snn_spike_readout

Overview:
- Downstream stage of the 3-layer LIF network. Consumes the output-layer spike vector (8 neurons) once per execute step.
- Accumulates per-neuron spike counts over a programmable window of steps, then runs a sequential argmax to produce a rate-coded class decision.
- Exposes the winner, its count, a tie flag and random-access readout of every counter, for the host to sample over the output pins.

Parameters:
- NEURONS, 8, number of output-layer neurons observed; must be >=2.
- COUNT_BITS, 8, width of each per-neuron saturating spike counter.
- WINDOW_BITS, 8, width of the window-length and step counter.
- IDX_BITS, $clog2(NEURONS), derived; width of neuron index; not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; latch window_len, zero counters, enter ACCUM.
- clear  input  1  synchronous abort; return to IDLE, zero counters and results.
- window_len  input  WINDOW_BITS  number of execute steps to accumulate; sampled only on start.
- spikes_valid  input  1  high for one cycle per network execute step.
- spikes  input  NEURONS  output-layer spike vector for this step.
- busy  output  1  high in ACCUM or ARGMAX.
- result_valid  output  1  high in DONE.
- winner  output  IDX_BITS  index of the neuron with the highest count.
- winner_count  output  COUNT_BITS  count of the winner.
- tie  output  1  another neuron equals winner_count.
- read_sel  input  IDX_BITS  counter readout select.
- read_data  output  COUNT_BITS  combinational counter[read_sel]; 0 if read_sel>=NEURONS.

Behaviour:
- Reset (rst_n low, async): state=IDLE, all counters=0, step=0, winner=0, winner_count=0, tie=0, busy=0, result_valid=0.
- Clock and reset are fixed: one clock (clk); reset rst_n is asynchronous and active-low. All other control is synchronous to clk.
- FSM states and transitions:
  - IDLE: wait for start.
  - ACCUM: count steps.
  - ARGMAX: sequential scan.
  - DONE: hold results.
- Priority, highest first: clear > start > normal transitions. Both apply in every state.
  - clear: next state IDLE; counters, step and results zeroed.
  - start: next state ACCUM; counters and step zeroed; window_len latched into win; results zeroed. If window_len==0, next state is ARGMAX instead of ACCUM.
- ACCUM, per cycle with spikes_valid=1:
  - counter[i] += spikes[i]; saturates at 2^COUNT_BITS-1 and never wraps.
  - step += 1.
  - If step+1==win, next state ARGMAX.
  - spikes_valid=0 cycles: no change.
- ARGMAX: scan index j=0..NEURONS-1, one per cycle, starting the cycle after entry.
  - j==0: best=counter[0], idx=0, tie=0.
  - j>0, counter[j]>best: best and idx updated, tie=0.
  - j>0, counter[j]==best: tie=1; lowest index is kept.
  - At j==NEURONS-1, next state DONE.
- Latency: if the final step is accepted at edge E, result_valid is high after edge E+NEURONS (8 cycles for default).
- DONE: outputs held stable until start or clear. spikes_valid is ignored in IDLE, ARGMAX and DONE.
- Counters are not modified during ARGMAX or DONE, so read_data stays coherent.
- start during ACCUM or ARGMAX: window aborted and restarted; no result_valid is produced for the aborted window.
- Simultaneous spikes_valid and start: counters are zeroed; that step is not counted.
- Async reset mid-operation: immediate return to reset values; no partial result is visible.

Decomposition:
- Shared package snn_pkg holds:
  - state enum {IDLE, ACCUM, ARGMAX, DONE}, 2-bit encoding.
  - Default constants: NEURONS_OUT=8, SPIKE_COUNT_BITS=8, WINDOW_BITS=8.
  - Saturating-max helper constant.
- Sub-module snn_sat_counter: one COUNT_BITS saturating incrementer with clear and enable, instantiated NEURONS times via generate.
- The FSM, step counter and argmax scanner stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-ACCUM → all outputs 0, state IDLE, read_data=0 for all sel.
- Basic: window_len=4, spikes 0x04 on 4 valid steps → result_valid 8 cycles after the 4th step; winner=2, winner_count=4, tie=0.
- Tie: window_len=3, spikes 0x82 each step → winner=1, winner_count=3, tie=1, read_data(sel=7)=3.
- Saturation: window_len=255, spikes 0x01 every cycle, COUNT_BITS=4 build → counter[0]=15, winner=0, winner_count=15.
- Zero window and abort:
  - window_len=0 → DONE after 8 cycles with winner=0, count=0, tie=1.
  - start mid-ACCUM with window_len=2 → counts restart; result reflects only the 2 new steps.
- Priority: clear and start asserted in the same cycle → IDLE, busy=0; spikes_valid coincident with start → not counted.
